// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between R requesters.
// Each request is granted in IDLE, executed from registered operands in
// EXEC, and returned on a tagged response channel in RESP.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// priority. Otherwise a round-robin pointer is built.
module alu_arbiter #(
    parameter int N = 4,
    parameter int R = 4,
    localparam int IW = (R > 1) ? $clog2(R) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [4*R-1:0] req_op,
    input  logic [N*R-1:0] req_a,
    input  logic [N*R-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IW-1:0]  rsp_id,
    output logic [N-1:0]   rsp_result,
    output logic [1:0]     rsp_flags,
    output logic           rsp_err,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [3:0]     alu_select,
    input  logic [N-1:0]   alu_result,
    input  logic [1:0]     alu_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          handshake;

    logic [3:0]    sel_op;
    logic [N-1:0]  sel_a;
    logic [N-1:0]  sel_b;

    logic [3:0]    op_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [IW-1:0] id_q;
    logic [N-1:0]  rsp_result_q;
    logic [1:0]    rsp_flags_q;
    logic          rsp_err_q;

    // Opcodes 10..15 have no ALU function.
    logic op_illegal;
    assign op_illegal = (op_q >= 4'd10);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest valid index wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (req_valid[IW'(i)]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr;

    // Round-robin: first valid index after the last grant, wrapping R-1 -> 0.
    always_comb begin
        int cand;
        // NOTE: every variable assigned in a combinational block gets a
        // default first; otherwise an unassigned path infers a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= R; k++) begin
            cand = int'(ptr) + k;
            if (cand >= R) cand = cand - R;
            if (!grant_valid && req_valid[IW'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

    // Pointer remembers the last granted requester; moves only on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= IW'(R - 1);
        else if (handshake) ptr <= grant_idx;
    end
`endif

    assign handshake = (state == IDLE) && grant_valid;

    // Mux the granted requester's opcode and operands out of the packed buses.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < R; i++) begin
            if (IW'(i) == grant_idx) begin
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[N*i +: N];
                sel_b  = req_b[N*i +: N];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (handshake) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: grant only in IDLE, response valid only in RESP.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE:    if (grant_valid) req_ready[grant_idx] = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture on handshake; result capture at the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (handshake) begin
                op_q <= sel_op;
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= grant_idx;
            end
            if (state == EXEC) begin
                if (op_illegal) begin
                    rsp_result_q <= '0;
                    rsp_flags_q  <= 2'b00;
                    rsp_err_q    <= 1'b1;
                end else begin
                    rsp_result_q <= alu_result;
                    rsp_flags_q  <= alu_flags;
                    rsp_err_q    <= 1'b0;
                end
            end
        end
    end

    assign alu_select = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU instance between R requesters. Each requester uses a valid/ready handshake to submit an opcode and two operands. The block grants one request at a time, drives the ALU from registered operands, and captures the ALU result and flags. It returns them on a single tagged response channel. It sits between the instruction-issue lanes and the shared ALU datapath.

## Interface
- N, 4, operand/result width (matches the ALU's N)
- R, 4, number of requesters (2..16); IW = $clog2(R)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  R  per-requester request valid
- req_ready  output  R  per-requester accept; at most one bit high
- req_op  input  4*R  opcode, requester i at [4i+3:4i]
- req_a  input  N*R  operand a, requester i at [N*i+N-1:N*i]
- req_b  input  N*R  operand b, same packing
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  IW  index of the requester that issued this response
- rsp_result  output  N  captured ALU result
- rsp_flags  output  2  captured ALU flags
- rsp_err  output  1  opcode was illegal (10..15)
- alu_a, alu_b  output  N  to the ALU a/b inputs
- alu_select  output  4  to the ALU select input
- alu_result  input  N  from the ALU result
- alu_flags  input  2  from the ALU flags

## Operation
- Opcodes: 0 mov, 1 compare, 2 add, 3 sub, 4 mul, 5 div, 6 xor, 7 and, 8 not, 9 mod. Values 10..15 are illegal.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE
  - The grant is computed combinationally from req_valid.
  - req_ready is high only for the granted index, and only when that requester's req_valid is high.
  - On handshake: latch op/a/b into the operand registers and the index into the id register, then go to EXEC.
  - With no valid requests, stay in IDLE; all req_ready stay 0.
- EXEC
  - alu_select/alu_a/alu_b are driven from the operand registers; they are stable for the whole state.
  - Legal opcode: capture alu_result and alu_flags into the rsp registers, rsp_err=0.
  - Illegal opcode: rsp_result=0, rsp_flags=2'b00, rsp_err=1.
  - Always advance to RESP.
- RESP
  - rsp_valid=1.
  - Hold rsp_id/rsp_result/rsp_flags/rsp_err stable until rsp_ready=1, then go to IDLE.
  - req_ready is 0 in this state (no grant overlap).
- Round-robin arbitration
  - A pointer holds the last-granted index.
  - Search starts at pointer+1 and wraps from R-1 to 0.
  - The pointer updates only on a request handshake.
- A requester that drops req_valid before being granted loses nothing; no request is latched without a handshake.
- alu_* outputs hold their last operand-register values outside EXEC. The ALU output is ignored outside EXEC.

## Timing
- Reset values: state IDLE, pointer R-1 (requester 0 wins first), operand/id/rsp registers 0. Outputs: req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, rsp_err 0, alu_a/alu_b/alu_select 0.
- Request handshake at edge t. alu_* carry the new operation during cycle t+1. rsp_valid is high from cycle t+2.
- Minimum issue interval is 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready held high).
- rst asserted in any state immediately clears all registers to their reset values. Any in-flight operation or pending response is discarded, with no response emitted.
- Simultaneous requests: exactly one is granted per IDLE cycle. Losers keep req_valid and are served in later rounds. No requester waits more than R grants.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest index with req_valid wins. The pointer register is not built.
  - Undefined (default): round-robin as described above.

## Test plan
- Single request: requester 1 sends op=2 (add), a=3, b=5. Expect req_ready[1] at t, alu_select=2 at t+1, then rsp_valid with rsp_id=1, rsp_result=8, rsp_err=0 at t+2.
- All four requesters valid continuously after reset, rsp_ready=1. Expect grant order 0,1,2,3,0, one grant every 3 cycles. With ALU_ARB_FIXED_PRIO_EN, requester 0 is granted every time.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Expect rsp_valid held and outputs unchanged, req_ready all 0, and return to IDLE the cycle after rsp_ready=1.
- Illegal op=12 from requester 2. Expect rsp_err=1, rsp_result=0, rsp_flags=0, rsp_id=2.
- Assert rst during EXEC. Expect all outputs at reset values immediately, no rsp_valid afterwards, and the next grant goes to requester 0.
- Flags passthrough: op=3 (sub), a=5, b=5. Expect rsp_result=0 and rsp_flags equal to the ALU's flags output for that operation.
